// File: rtl/queue_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// queue_xfer_ctrl
//
// Moves words from the deserializer into the 8-entry queue. The deserializer
// side uses a four-phase ready/ack handshake. The queue side receives one-cycle
// enqueue/dequeue strobes, and each strobe is confirmed by watching q_len_in
// move by one. A level-sensitive drain request dequeues one word per tick.
// Queue operations are paced by an internal tick, which is a clock enable and
// not a derived clock.
//
// Optional feature (macro DROP_ON_FULL_EN):
//   defined   - a word that meets a full queue on a tick is dropped and acked,
//               and drop_cnt_out counts it (saturating at 255).
//   undefined - a full queue back-pressures the deserializer (no ack), and
//               drop_cnt_out is tied to 0.
//
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous, active-low reset
//   des_ready_in   in   deserializer word valid (level, held until ack)
//   des_data_in    in   deserializer word [7:0]
//   des_ack_out    out  four-phase ack to the deserializer
//   q_data_out     out  word presented to the queue [7:0]
//   q_enqueue_out  out  one-cycle enqueue strobe (tick cycles only)
//   q_dequeue_out  out  one-cycle dequeue strobe (tick cycles only)
//   q_len_in       in   current queue length [3:0]
//   drain_req_in   in   level: dequeue one word per tick while non-empty
//   full_out       out  registered (q_len_in == DEPTH)
//   err_out        out  sticky confirmation-timeout flag
//   drop_cnt_out   out  saturating count of dropped words [7:0]
// -----------------------------------------------------------------------------
module queue_xfer_ctrl #(
   parameter int DEPTH      = 8,
   parameter int TICK_DIV   = 10,
   parameter int CONFIRM_TO = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       des_ready_in,
   input  logic [7:0] des_data_in,
   output logic       des_ack_out,
   output logic [7:0] q_data_out,
   output logic       q_enqueue_out,
   output logic       q_dequeue_out,
   input  logic [3:0] q_len_in,
   input  logic       drain_req_in,
   output logic       full_out,
   output logic       err_out,
   output logic [7:0] drop_cnt_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_WAIT_TICK,
      S_CONFIRM,
      S_ACK_HI,
      S_ACK_LO,
      S_DRAIN_CONF
   } state_t;

   localparam logic [3:0] L_DEPTH     = 4'(DEPTH);
   localparam logic [7:0] L_TICK_LAST = 8'(TICK_DIV - 1);
   localparam logic [7:0] L_TICK_PRE  = 8'(TICK_DIV - 2);
   localparam logic [7:0] L_CONF_TO   = 8'(CONFIRM_TO);

   state_t     r_state;
   logic [7:0] r_tick_cnt;
   logic [7:0] r_to_cnt;
   logic [3:0] r_snap;
   logic [7:0] r_data;
   logic       r_ack;
   logic       r_enq;
   logic       r_deq;
   logic       r_full;
   logic       r_err;

   logic       w_tick;
   logic       w_pre_tick;
   logic       w_q_full;
   logic       w_q_empty;

   // Strobes are registered, so the decision to issue one is taken in the
   // cycle before the tick. The strobe is then high during the tick cycle.
   assign w_tick     = (r_tick_cnt == L_TICK_LAST);
   assign w_pre_tick = (r_tick_cnt == L_TICK_PRE);
   assign w_q_full   = (q_len_in >= L_DEPTH);
   assign w_q_empty  = (q_len_in == 4'd0);

   // NOTE: all clocked state uses non-blocking assignments, so every register
   // in a block samples the pre-edge values of the others.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_tick_cnt <= 8'd0;
      end else if (w_tick) begin
         r_tick_cnt <= 8'd0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 8'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_full <= 1'b0;
      end else begin
         r_full <= (q_len_in == L_DEPTH);
      end
   end

`ifdef DROP_ON_FULL_EN
   logic [7:0] r_drop_cnt;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_to_cnt <= 8'd0;
         r_snap   <= 4'd0;
         r_data   <= 8'd0;
         r_ack    <= 1'b0;
         r_enq    <= 1'b0;
         r_deq    <= 1'b0;
         r_err    <= 1'b0;
`ifdef DROP_ON_FULL_EN
         r_drop_cnt <= 8'd0;
`endif
      end else begin
         // NOTE: the strobes default low every cycle. A branch that sets one
         // therefore produces exactly one cycle of strobe and never a stuck
         // level.
         r_enq <= 1'b0;
         r_deq <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (des_ready_in) begin
                  r_state <= S_LATCH;
               end else if (drain_req_in && !w_q_empty && w_pre_tick) begin
                  r_deq    <= 1'b1;
                  r_snap   <= q_len_in;
                  r_to_cnt <= 8'd0;
                  r_state  <= S_DRAIN_CONF;
               end
            end

            S_LATCH: begin
               r_data  <= des_data_in;
               r_snap  <= q_len_in;
               r_state <= S_WAIT_TICK;
            end

            S_WAIT_TICK: begin
               if (w_pre_tick && !w_q_full) begin
                  r_enq    <= 1'b1;
                  r_snap   <= q_len_in;
                  r_to_cnt <= 8'd0;
                  r_state  <= S_CONFIRM;
`ifdef DROP_ON_FULL_EN
               end else if (w_tick && w_q_full) begin
                  if (r_drop_cnt != 8'hFF) begin
                     r_drop_cnt <= r_drop_cnt + 8'd1;
                  end
                  r_ack   <= 1'b1;
                  r_state <= S_ACK_HI;
               end
`else
               end else if (w_pre_tick && drain_req_in) begin
                  // A full queue lets a pending drain take this tick.
                  // Otherwise back-pressure with drain active would deadlock.
                  // IDLE re-latches the word because the deserializer holds
                  // it until ack.
                  r_deq    <= 1'b1;
                  r_snap   <= q_len_in;
                  r_to_cnt <= 8'd0;
                  r_state  <= S_DRAIN_CONF;
               end
`endif
            end

            S_CONFIRM: begin
               if (q_len_in == r_snap + 4'd1) begin
                  r_ack   <= 1'b1;
                  r_state <= S_ACK_HI;
               end else if (w_tick) begin
                  // The issuing tick is counted first, so the timeout fires
                  // CONFIRM_TO full ticks after the strobe.
                  if (r_to_cnt == L_CONF_TO) begin
                     r_err   <= 1'b1;
                     r_ack   <= 1'b1;
                     r_state <= S_ACK_HI;
                  end else begin
                     r_to_cnt <= r_to_cnt + 8'd1;
                  end
               end
            end

            S_ACK_HI: begin
               if (!des_ready_in) begin
                  r_ack   <= 1'b0;
                  r_state <= S_ACK_LO;
               end
            end

            S_ACK_LO: begin
               r_state <= S_IDLE;
            end

            S_DRAIN_CONF: begin
               if (q_len_in == r_snap - 4'd1) begin
                  r_state <= S_IDLE;
               end else if (w_tick) begin
                  if (r_to_cnt == L_CONF_TO) begin
                     r_err   <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_to_cnt <= r_to_cnt + 8'd1;
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign des_ack_out   = r_ack;
   assign q_data_out    = r_data;
   assign q_enqueue_out = r_enq;
   assign q_dequeue_out = r_deq;
   assign full_out      = r_full;
   assign err_out       = r_err;
`ifdef DROP_ON_FULL_EN
   assign drop_cnt_out  = r_drop_cnt;
`else
   assign drop_cnt_out  = 8'd0;
`endif

endmodule

// File: tb/tb_queue_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_queue_xfer_ctrl
//
// Bench for queue_xfer_ctrl. The queue is modelled as a byte queue whose length
// drives q_len_in. The model can be told to ignore enqueues so the
// confirmation timeout can be provoked. Expected queue contents are kept as a
// list of words that the stimulus believes were accepted. Strobe timing is
// checked against a free-running cycle index counted from reset release.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_queue_xfer_ctrl;

   localparam int DEPTH      = 8;
   localparam int TICK_DIV   = 10;
   localparam int CONFIRM_TO = 4;
   localparam int BUDGET     = 20 * TICK_DIV;

   logic       clock;
   logic       reset;
   logic       des_ready_in;
   logic [7:0] des_data_in;
   logic       des_ack_out;
   logic [7:0] q_data_out;
   logic       q_enqueue_out;
   logic       q_dequeue_out;
   logic [3:0] q_len_in;
   logic       drain_req_in;
   logic       full_out;
   logic       err_out;
   logic [7:0] drop_cnt_out;

   queue_xfer_ctrl #(
      .DEPTH      (DEPTH),
      .TICK_DIV   (TICK_DIV),
      .CONFIRM_TO (CONFIRM_TO)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .des_ready_in  (des_ready_in),
      .des_data_in   (des_data_in),
      .des_ack_out   (des_ack_out),
      .q_data_out    (q_data_out),
      .q_enqueue_out (q_enqueue_out),
      .q_dequeue_out (q_dequeue_out),
      .q_len_in      (q_len_in),
      .drain_req_in  (drain_req_in),
      .full_out      (full_out),
      .err_out       (err_out),
      .drop_cnt_out  (drop_cnt_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- queue model ----------------
   logic [7:0] mem[$];
   logic [3:0] q_len;
   bit         ignore_enq;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem.delete();
         q_len <= 4'd0;
      end else begin
         if (q_enqueue_out && !ignore_enq && mem.size() < DEPTH) mem.push_back(q_data_out);
         if (q_dequeue_out && mem.size() > 0) void'(mem.pop_front());
         q_len <= 4'(mem.size());
      end
   end
   assign q_len_in = q_len;

   // ---------------- monitor ----------------
   int         cyc;
   int         enq_cnt = 0;
   int         deq_cnt = 0;
   int         last_enq_cyc = 0;
   int         err_rise_cyc = 0;
   logic       err_prev = 1'b0;
   logic [7:0] cur_word;

   always @(posedge clock or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge clock) begin
      if (reset) begin
         if (q_enqueue_out || q_dequeue_out) begin
            check("strobe_on_tick", 32'(cyc % TICK_DIV), 32'(TICK_DIV - 1));
            check("strobe_excl", 32'(q_enqueue_out & q_dequeue_out), 32'd0);
         end
         if (q_enqueue_out) begin
            enq_cnt      <= enq_cnt + 1;
            last_enq_cyc <= cyc;
            check("enq_data", 32'(q_data_out), 32'(cur_word));
         end
         if (q_dequeue_out) deq_cnt <= deq_cnt + 1;
         if (err_out && !err_prev) err_rise_cyc <= cyc;
      end
      err_prev <= err_out;
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] exp_q[$];
   int         exp_drops = 0;

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   function automatic logic [31:0] outs_vec();
      return 32'({des_ack_out, q_enqueue_out, q_dequeue_out, full_out, err_out,
                  q_data_out, drop_cnt_out});
   endfunction

   task automatic wait_ack(output bit ok);
      for (int i = 0; i < BUDGET && !des_ack_out; i++) step();
      check("ack_wait", 32'(des_ack_out), 32'd1);
      ok = des_ack_out;
   endtask

   // Called with ack high: hold ready a random while, then release it and
   // expect ack to fall exactly one cycle later.
   task automatic finish_word();
      repeat ($urandom_range(0, 3)) begin
         step();
         check("ack_hold", 32'(des_ack_out), 32'd1);
      end
      des_ready_in = 1'b0;
      step();
      check("ack_fall", 32'(des_ack_out), 32'd0);
   endtask

   task automatic wait_deq(input int d0, input int n);
      for (int i = 0; i < BUDGET * n && (deq_cnt - d0) < n; i++) step();
      check("deq_wait", 32'(deq_cnt - d0), 32'(n));
   endtask

   task automatic send_word(input logic [7:0] d);
      int e0;
      bit ok;
      bit exp_enq;
      exp_enq      = (exp_q.size() < DEPTH);
      e0           = enq_cnt;
      cur_word     = d;
      des_data_in  = d;
      des_ready_in = 1'b1;
      wait_ack(ok);
      check("enq_count", 32'(enq_cnt - e0), exp_enq ? 32'd1 : 32'd0);
      if (ok) finish_word();
      else    des_ready_in = 1'b0;
      if (exp_enq) exp_q.push_back(d);
      else         exp_drops++;
      step();
      check("q_len", 32'(q_len), 32'(exp_q.size()));
   endtask

   task automatic drain_n(input int n);
      int d0;
      d0           = deq_cnt;
      drain_req_in = 1'b1;
      wait_deq(d0, n);
      drain_req_in = 1'b0;
      repeat (n) if (exp_q.size() > 0) void'(exp_q.pop_front());
      steps(3);
      check("drain_len", 32'(q_len), 32'(exp_q.size()));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int         e0;
      int         d0;
      int         delta;
      bit         ok;
      bit         can_send;
      logic [7:0] d;

      reset        = 1'b0;
      des_ready_in = 1'b1;
      des_data_in  = 8'hA5;
      cur_word     = 8'hA5;
      drain_req_in = 1'b0;
      ignore_enq   = 1'b0;

      // Reset held with a word pending: every output stays 0.
      repeat (4) begin
         step();
         check("reset_outs", outs_vec(), 32'd0);
      end
      reset = 1'b1;

      // The pending 0xA5 goes into the empty queue on the first tick.
      wait_ack(ok);
      check("first_enq_count", 32'(enq_cnt), 32'd1);
      check("first_enq_cyc", 32'(last_enq_cyc), 32'(TICK_DIV - 1));
      check("first_len", 32'(q_len), 32'd1);
      check("first_err", 32'(err_out), 32'd0);
      if (ok) finish_word();
      else    des_ready_in = 1'b0;
      exp_q.push_back(8'hA5);
      step();

      // Fill to DEPTH.
      for (int i = 0; i < DEPTH - 1; i++) send_word(8'($urandom));
      check("full_at_depth", 32'(full_out), 32'd1);

      // Ninth word against a full queue.
      d = 8'($urandom);
`ifndef DROP_ON_FULL_EN
      e0           = enq_cnt;
      cur_word     = d;
      des_data_in  = d;
      des_ready_in = 1'b1;
      steps(3 * TICK_DIV);
      check("bp_no_enq", 32'(enq_cnt - e0), 32'd0);
      check("bp_no_ack", 32'(des_ack_out), 32'd0);
      check("bp_full", 32'(full_out), 32'd1);
      d0           = deq_cnt;
      drain_req_in = 1'b1;
      wait_deq(d0, 1);
      drain_req_in = 1'b0;
      void'(exp_q.pop_front());
      wait_ack(ok);
      check("bp_enq", 32'(enq_cnt - e0), 32'd1);
      if (ok) finish_word();
      else    des_ready_in = 1'b0;
      exp_q.push_back(d);
      step();
      check("bp_len", 32'(q_len), 32'(DEPTH));
`else
      send_word(d);
      check("drop_cnt_one", 32'(drop_cnt_out), 32'd1);
      check("drop_len", 32'(q_len), 32'(DEPTH));
`endif

      // Bring the queue down to 3, then raise ready and drain together.
      drain_n(DEPTH - 3);
      check("len_three", 32'(q_len), 32'd3);
      d            = 8'($urandom);
      e0           = enq_cnt;
      d0           = deq_cnt;
      cur_word     = d;
      des_data_in  = d;
      des_ready_in = 1'b1;
      drain_req_in = 1'b1;
      wait_ack(ok);
      check("prio_enq", 32'(enq_cnt - e0), 32'd1);
      check("prio_no_deq", 32'(deq_cnt - d0), 32'd0);
      if (ok) finish_word();
      else    des_ready_in = 1'b0;
      exp_q.push_back(d);
      wait_deq(d0, 4);
      steps(3 * TICK_DIV);
      drain_req_in = 1'b0;
      check("drain_four", 32'(deq_cnt - d0), 32'd4);
      check("drain_empty", 32'(q_len), 32'd0);
      repeat (4) void'(exp_q.pop_front());

      // Random mix of words and drains.
      for (int i = 0; i < 40; i++) begin
         can_send = (exp_q.size() < DEPTH);
`ifdef DROP_ON_FULL_EN
         can_send = 1'b1;
`endif
         if ($urandom_range(0, 2) == 0 && exp_q.size() > 0)
            drain_n((exp_q.size() < 3) ? exp_q.size() : int'($urandom_range(1, 3)));
         else if (can_send)
            send_word(8'($urandom));
         else
            drain_n(1);
         steps($urandom_range(0, 5));
      end
      check("sb_size", 32'(mem.size()), 32'(exp_q.size()));
      for (int i = 0; i < mem.size() && i < exp_q.size(); i++)
         check("sb_word", 32'(mem[i]), 32'(exp_q[i]));
      check("drop_total", 32'(drop_cnt_out), 32'(exp_drops));

      // Queue ignores an enqueue: timeout raises err and the ack still completes.
      if (exp_q.size() >= DEPTH) drain_n(1);
      check("err_before", 32'(err_out), 32'd0);
      ignore_enq   = 1'b1;
      d            = 8'($urandom);
      e0           = enq_cnt;
      cur_word     = d;
      des_data_in  = d;
      des_ready_in = 1'b1;
      wait_ack(ok);
      check("to_enq", 32'(enq_cnt - e0), 32'd1);
      check("to_err", 32'(err_out), 32'd1);
      delta = err_rise_cyc - last_enq_cyc;
      check("to_delay_window",
            32'(delta >= CONFIRM_TO * TICK_DIV && delta <= (CONFIRM_TO + 1) * TICK_DIV), 32'd1);
      if (ok) finish_word();
      else    des_ready_in = 1'b0;
      ignore_enq = 1'b0;
      step();
      check("to_len", 32'(q_len), 32'(exp_q.size()));
      if (exp_q.size() >= DEPTH) drain_n(1);
      send_word(8'($urandom));
      check("err_sticky", 32'(err_out), 32'd1);

      // Reset in the middle of a transfer.
      des_data_in  = 8'($urandom);
      des_ready_in = 1'b1;
      steps(3);
      reset = 1'b0;
      repeat (3) begin
         step();
         check("midreset_outs", outs_vec(), 32'd0);
      end
      des_ready_in = 1'b0;
      reset        = 1'b1;
      exp_q.delete();
      e0 = enq_cnt;
      d0 = deq_cnt;
      steps(2 * TICK_DIV);
      check("post_reset_quiet", 32'((enq_cnt - e0) + (deq_cnt - d0)), 32'd0);
      check("post_reset_outs", outs_vec(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/queue_xfer_ctrl.md
Name: queue_xfer_ctrl

Overview:
- Single-clock controller that sequences word transfers from the deserializer into the 8-entry queue.
- Replaces the ad-hoc ack derived from len_out changes with an explicit four-phase handshake toward the deserializer, paced enqueue/dequeue strobes toward the queue, and queue-side confirmation.
- Arbitrates between the enqueue path and a drain (dequeue) request.
- Sits in top between the deserializer and the queue. Queue operations are pulsed on an internal tick (clock enable), not a derived clock.

Parameters:
- DEPTH, 8, queue capacity in words; full when q_len_in == DEPTH.
- TICK_DIV, 10, clock cycles per queue-operation tick (range 2..255).
- CONFIRM_TO, 4, ticks allowed for q_len_in to reflect an issued operation before error.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- des_ready_in  in  1  deserializer word valid (level, held until ack)
- des_data_in  in  8  deserializer word
- des_ack_out  out  1  four-phase ack to deserializer
- q_data_out  out  8  word presented to queue
- q_enqueue_out  out  1  one-cycle enqueue strobe
- q_dequeue_out  out  1  one-cycle dequeue strobe
- q_len_in  in  4  current queue length
- drain_req_in  in  1  level: dequeue one word per tick while high and queue non-empty
- full_out  out  1  q_len_in == DEPTH (registered)
- err_out  out  1  sticky: confirmation timeout
- drop_cnt_out  out  8  words dropped (saturating; see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; tick counter = 0.
  - All outputs 0; q_data_out = 0; err_out and drop_cnt_out cleared.
  - Reset mid-transfer abandons the word. No strobe or ack may glitch high during or after reset.
- Tick: counter runs 0..TICK_DIV-1; tick = 1 for one cycle when counter == TICK_DIV-1. Queue strobes are asserted only in a tick cycle.
- FSM states: IDLE, LATCH, WAIT_TICK, CONFIRM, ACK_HI, ACK_LO, DRAIN_CONF.
- IDLE:
  - des_ready_in = 1 -> LATCH. Enqueue has priority over drain.
  - Else drain_req_in = 1 and q_len_in != 0 and tick -> pulse q_dequeue_out, snapshot len -> DRAIN_CONF.
- LATCH: capture des_data_in into q_data_out; snapshot q_len_in -> WAIT_TICK. Latency: 1 cycle.
- WAIT_TICK: on tick with q_len_in < DEPTH -> pulse q_enqueue_out (exactly 1 cycle), re-snapshot len -> CONFIRM.
  - Full with DROP_ON_FULL_EN undefined: stay here (backpressure; no ack, deserializer stalls).
- CONFIRM:
  - q_len_in == snap+1 -> ACK_HI.
  - CONFIRM_TO ticks elapsed -> set err_out, go to ACK_HI anyway (no deadlock).
- ACK_HI: des_ack_out = 1 until des_ready_in = 0, then ACK_LO.
- ACK_LO: des_ack_out = 0 for one cycle -> IDLE. Back-to-back words therefore need at least one idle cycle.
- DRAIN_CONF: q_len_in == snap-1 or timeout (set err_out) -> IDLE.
- Mutual exclusion: q_enqueue_out and q_dequeue_out are never high in the same cycle. At most one queue op per tick.
- q_data_out is stable from LATCH until the next LATCH.
- full_out updates every cycle from q_len_in.
- Snapshot arithmetic is 4-bit unsigned; DEPTH ≤ 15 so it cannot wrap.

Optional Feature:
- Macro: DROP_ON_FULL_EN.
- Defined: in WAIT_TICK with the queue full on a tick, do not enqueue. Increment drop_cnt_out (saturate at 255) and go directly to ACK_HI, so the deserializer never stalls.
- Undefined: backpressure as above; drop_cnt_out is tied to 0.

Test Plan:
- Reset with des_ready_in high -> all outputs 0 for the whole reset; after release, first q_enqueue_out lands on a tick cycle (cycle index ≡ TICK_DIV-1).
- Word 0xA5, queue len 0 -> one q_enqueue_out pulse with q_data_out = 0xA5; queue model raises len to 1; des_ack_out rises; after des_ready_in drops, ack falls one cycle later.
- Fill 8 words, send 9th (macro off) -> no enqueue, no ack, full_out = 1. Drain one word -> 9th enqueued and acked; final len = 8.
- Same as above with DROP_ON_FULL_EN -> 9th word acked without enqueue; drop_cnt_out = 1; len stays 8.
- drain_req_in high with len 3 and a concurrent des_ready_in -> enqueue first. Then 4 dequeue pulses on 4 distinct ticks. Strobes never overlap; final len 0.
- Queue model ignores the enqueue -> after CONFIRM_TO = 4 ticks, err_out = 1 (sticky) and ack still completes.
